out_arb: RTL and testbench

- Per-output-port arbiter and output mux for the packet switch. One instance per output port.
- Collects the request bit aimed at its output from every input-buffer state machine and grants exactly one with round-robin priority (ack).
- Holds that grant for the whole packet and drives the granted input's flits onto the output until the TAIL flit has passed.

---
 rtl/out_arb.sv | 125 ++++++++++++
 tb/tb_out_arb.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_arb.sv
// rtl/out_arb.sv - per-output round-robin arbiter and packet mux
// Optional: OUT_ARB_HANDOVER_EN enables zero-bubble grant handover on TAIL.
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 15
`endif
`ifndef FLOWBH
`define FLOWBH 15
`endif
`ifndef FLOWBL
`define FLOWBL 14
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module out_arb #(
   parameter int NIN  = 4,
   parameter int PTRW = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [`PORT:0]   req,
   input  logic [`PKTW:0]   pkt0,
   input  logic [`PKTW:0]   pkt1,
   input  logic [`PKTW:0]   pkt2,
   input  logic [`PKTW:0]   pkt3,
   output logic [`PORT:0]   ack,
   output logic [PTRW-1:0]  sel,
   output logic [`PKTW:0]   pkto,
   output logic             vo
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_n;
   logic [PTRW-1:0]  ptr, ptr_n, sel_n;
   logic [`PORT:0]   ack_n;
   logic [PTRW-1:0]  scan_base, win, idx;
   logic [`PORT:0]   scan_req;
   logic             found;
   logic [`PKTW:0]   cur;
   logic             tail;

   always_comb begin
      cur = pkt3;
      case (sel)
         2'd0:    cur = pkt0;
         2'd1:    cur = pkt1;
         2'd2:    cur = pkt2;
         default: cur = pkt3;
      endcase
   end

   assign tail = (state == BUSY) && (cur[`FLOWBH:`FLOWBL] == `TAIL);
   assign pkto = (state == BUSY) ? cur : '0;
   assign vo   = (state == BUSY);

   // In BUSY the scan is only used on TAIL for handover: owner masked, start after owner.
   always_comb begin
      scan_base = ptr;
      scan_req  = req;
      if (state == BUSY) begin
         scan_base = sel + 1'b1;
         scan_req  = req & ~ack;
      end
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < NIN; k++) begin
         idx = scan_base + PTRW'(k);
         if (!found && scan_req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      sel_n   = sel;
      ack_n   = ack;
      case (state)
         IDLE: begin
            if (found) begin
               state_n = BUSY;
               sel_n   = win;
               ack_n   = {{`PORT{1'b0}}, 1'b1} << win;
            end
         end
         default: begin
            if (tail) begin
               ptr_n   = sel + 1'b1;
               state_n = IDLE;
               ack_n   = '0;
`ifdef OUT_ARB_HANDOVER_EN
               if (found) begin
                  state_n = BUSY;
                  sel_n   = win;
                  ack_n   = {{`PORT{1'b0}}, 1'b1} << win;
               end
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         sel   <= '0;
         ack   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         sel   <= sel_n;
         ack   <= ack_n;
      end
   end

endmodule

// File: tb/tb_out_arb.sv
// tb/tb_out_arb.sv - self-checking bench for out_arb against a packet-level model
`ifndef PORT
`define PORT 3
`endif
`ifndef PKTW
`define PKTW 15
`endif
`ifndef TAIL
`define TAIL 2'b10
`endif

module tb_out_arb;
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b00;
   localparam int GAP =
`ifdef OUT_ARB_HANDOVER_EN
      2;
`else
      3;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [15:0]   pkt0, pkt1, pkt2, pkt3;
   logic [3:0]    ack;
   logic [1:0]    sel;
   logic [15:0]   pkto;
   logic          vo;

   always #5 clk = ~clk;

   out_arb #(.NIN(4), .PTRW(2)) dut (
      .clk(clk), .rst(rst), .req(req),
      .pkt0(pkt0), .pkt1(pkt1), .pkt2(pkt2), .pkt3(pkt3),
      .ack(ack), .sel(sel), .pkto(pkto), .vo(vo)
   );

   int checks = 0;
   int failures = 0;

   // packet-level model: who owns the output, and where the next scan starts
   int m_busy, m_owner, m_ptr;
   int act[4], idx[4], len[4], refill[4];
   logic [13:0] pay [4][16];
   logic [15:0] flit [4];
   bit noise_en = 0;
   int cyc = 0;
   int gq[$];
   int gc[$];

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cur_flit(int i);
      logic [1:0] fl;
      if (act[i] == 0) return 16'h0;
      fl = (idx[i] == 0) ? HEAD : (idx[i] == len[i] - 1) ? `TAIL : BODY;
      return {fl, pay[i][idx[i]]};
   endfunction

   task automatic start_pkt(int i, int n);
      act[i] = 1;
      idx[i] = 0;
      len[i] = n;
      for (int k = 0; k < 16; k++) pay[i][k] = 14'($urandom);
   endtask

   function automatic int pick(logic [3:0] r, int start, int excl);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (j != excl && r[j]) return j;
      end
      return -1;
   endfunction

   function automatic bit any_act();
      return (act[0] | act[1] | act[2] | act[3]) != 0;
   endfunction

   // one clock: drive inputs, check outputs, advance model and input buffers
   task automatic tick(bit r);
      logic [3:0] rq, eack;
      logic [15:0] epk;
      bit tl;
      int nb, no, np, w;
      for (int i = 0; i < 4; i++) flit[i] = cur_flit(i);
      pkt0 = flit[0]; pkt1 = flit[1]; pkt2 = flit[2]; pkt3 = flit[3];
      tl = (m_busy != 0) && (flit[m_owner][15:14] == `TAIL);
      for (int i = 0; i < 4; i++)
         rq[i] = (act[i] != 0) && (idx[i] == 0) && !(m_busy != 0 && m_owner == i);
      if (noise_en && m_busy != 0 && !tl) rq = rq | 4'($urandom);
      req = rq;
      rst = r;
      #1;
      eack = (m_busy != 0) ? 4'(1 << m_owner) : 4'h0;
      epk  = (m_busy != 0) ? flit[m_owner] : 16'h0;
      chk("ack", 32'(ack), 32'(eack));
      chk("vo", 32'(vo), 32'(m_busy != 0));
      chk("pkto", 32'(pkto), 32'(epk));
      if (m_busy != 0) chk("sel", 32'(sel), 32'(m_owner));
      nb = m_busy; no = m_owner; np = m_ptr;
      if (r) begin
         nb = 0; no = 0; np = 0;
      end else if (m_busy == 0) begin
         w = pick(rq, m_ptr, -1);
         if (w >= 0) begin nb = 1; no = w; end
      end else if (tl) begin
         np = (m_owner + 1) % 4;
         nb = 0;
`ifdef OUT_ARB_HANDOVER_EN
         w = pick(rq, (m_owner + 1) % 4, m_owner);
         if (w >= 0) begin nb = 1; no = w; end
`endif
      end
      if (!r && nb != 0 && (m_busy == 0 || tl)) begin
         gq.push_back(no);
         gc.push_back(cyc + 1);
      end
      if (m_busy != 0) begin
         if (r) act[m_owner] = 0;
         else begin
            idx[m_owner]++;
            if (idx[m_owner] == len[m_owner]) begin
               act[m_owner] = 0;
               if (refill[m_owner] > 0) begin
                  refill[m_owner]--;
                  start_pkt(m_owner, len[m_owner]);
               end
            end
         end
      end
      m_busy = nb; m_owner = no; m_ptr = np;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain(int budget);
      int left;
      left = budget;
      while ((m_busy != 0 || any_act()) && left > 0) begin
         tick(0);
         left--;
      end
      checks++;
      assert (left > 0) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d expected=>0", left);
      end
   endtask

   task automatic exp_grants(string tag, int n, int g0, int g1, int g2, int g3, int g4);
      int e[5];
      e = '{g0, g1, g2, g3, g4};
      chk({tag, "_count"}, 32'(gq.size()), 32'(n));
      for (int k = 0; k < n && k < gq.size(); k++)
         chk({tag, "_order"}, 32'(gq[k]), 32'(e[k]));
   endtask

   task automatic do_reset();
      tick(1);
      gq.delete();
      gc.delete();
   endtask

   initial begin
      int c0, hold;
      for (int i = 0; i < 4; i++) begin act[i] = 0; idx[i] = 0; len[i] = 2; refill[i] = 0; end
      m_busy = 0; m_owner = 0; m_ptr = 0;
      rst = 1'b1; req = '0; pkt0 = '0; pkt1 = '0; pkt2 = '0; pkt3 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_vo", 32'(vo), 0);
      chk("rst_pkto", 32'(pkto), 0);
      chk("rst_sel", 32'(sel), 0);

      // single 3-flit packet on input 2, then pointer sits at 3
      tick(1);
      start_pkt(2, 3);
      c0 = cyc;
      drain(20);
      exp_grants("single", 1, 2, 0, 0, 0, 0);
      if (gc.size() > 0) chk("single_lat", 32'(gc[0]), 32'(c0 + 1));
      gq.delete(); gc.delete();
      start_pkt(0, 2);
      start_pkt(3, 2);
      drain(20);
      exp_grants("wrap", 2, 3, 0, 0, 0, 0);

      // all four requesting, 2-flit packets
      do_reset();
      for (int i = 0; i < 4; i++) start_pkt(i, 2);
      refill[0] = 1;
      drain(40);
      exp_grants("rr", 5, 0, 1, 2, 3, 0);
      for (int k = 0; k + 1 < gc.size() && k < 4; k++)
         chk("rr_gap", 32'(gc[k+1] - gc[k]), 32'(GAP));

      // requests arriving while owner 1 is busy
      do_reset();
      start_pkt(1, 4);
      tick(0);
      start_pkt(0, 2);
      start_pkt(2, 2);
      drain(30);
      exp_grants("busyreq", 3, 1, 2, 0, 0, 0);

      // reset in the middle of a 5-flit packet
      do_reset();
      start_pkt(2, 2);
      drain(20);
      start_pkt(1, 5);
      repeat (3) tick(0);
      tick(1);
      chk("midrst_ack", 32'(ack), 0);
      chk("midrst_vo", 32'(vo), 0);
      chk("midrst_pkto", 32'(pkto), 0);
      chk("midrst_sel", 32'(sel), 0);
      gq.delete(); gc.delete();
      start_pkt(1, 2);
      start_pkt(3, 2);
      c0 = cyc;
      drain(20);
      exp_grants("postrst", 2, 1, 3, 0, 0, 0);
      if (gc.size() > 0) chk("postrst_lat", 32'(gc[0]), 32'(c0 + 1));

      // 16-flit packet with other request bits toggling
      do_reset();
      noise_en = 1;
      start_pkt(2, 16);
      hold = 0;
      for (int k = 0; k < 20; k++) begin
         tick(0);
         if (ack === 4'b0100 && sel === 2'd2) hold++;
      end
      noise_en = 0;
      chk("long_hold", 32'(hold), 16);

      // random traffic
      do_reset();
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 4; i++)
            if (act[i] == 0 && ($urandom % 6) == 0) start_pkt(i, 2 + int'($urandom % 6));
         tick(0);
      end
      drain(200);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
